// File: rtl/cacc_frame_pkg.sv
// cacc_frame_pkg -- shared types and helpers for the complex frame accumulator.
//   state_e    : frame FSM states (IDLE, ACC, HOLD)
//   sat_res_t  : result of a saturating add (value plus overflow flag)
//   sat_add    : signed add clamped to a caller-supplied width (w <= 63)
package cacc_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int SAT_MAXW = 64;

    typedef struct packed {
        logic                       ovf;
        logic signed [SAT_MAXW-1:0] val;
    } sat_res_t;

    // Operands arrive sign-extended to SAT_MAXW; the sum is formed one bit
    // wider so it can never wrap before being compared against the w-bit range.
    function automatic sat_res_t sat_add(input logic signed [SAT_MAXW-1:0] a,
                                         input logic signed [SAT_MAXW-1:0] b,
                                         input int                         w);
        logic signed [SAT_MAXW:0] s;
        logic signed [SAT_MAXW:0] hi;
        logic signed [SAT_MAXW:0] lo;
        sat_res_t                 r;
        s     = {a[SAT_MAXW-1], a} + {b[SAT_MAXW-1], b};
        hi    = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo    = -hi - 65'sd1;
        r.ovf = 1'b0;
        r.val = s[SAT_MAXW-1:0];
        if (s > hi) begin
            r.val = hi[SAT_MAXW-1:0];
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.val = lo[SAT_MAXW-1:0];
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cacc_lane.sv
// cacc_lane -- one signed accumulate lane of the frame accumulator.
// Build option: CACC_FRAME_SAT_EN defined -> adds clamp to the ACCW range and
// set a sticky overflow flag; undefined -> adds wrap and the flag stays 0.
// Ports:
//   clk, rst_n, ce  clock, async active-low reset, clock enable
//   load_i          first beat of a frame: acc takes the sign-extended input
//   add_i           later beat: acc accumulates the input
//   clr_i           frame closes on this beat: clear acc and flag afterwards
//   din_i           signed input component
//   sum_o, ovf_o    value/flag the accumulator would hold after this beat
module cacc_lane
    import cacc_frame_pkg::*;
#(
    parameter int SIZEIN = 16,
    parameter int ACCW   = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     load_i,
    input  logic                     add_i,
    input  logic                     clr_i,
    input  logic signed [SIZEIN-1:0] din_i,
    output logic signed [ACCW-1:0]   sum_o,
    output logic                     ovf_o
);

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic signed [ACCW-1:0] din_ext;
    logic signed [ACCW-1:0] add_sum;
    logic                   add_ovf;

    assign din_ext = ACCW'(din_i);

`ifdef CACC_FRAME_SAT_EN
    sat_res_t add_res;
    logic     unused_hi;
    assign add_res   = sat_add(SAT_MAXW'(acc_q), SAT_MAXW'(din_ext), ACCW);
    assign add_sum   = add_res.val[ACCW-1:0];
    assign add_ovf   = add_res.ovf;
    assign unused_hi = ^add_res.val[SAT_MAXW-1:ACCW];
`else
    assign add_sum = acc_q + din_ext;
    assign add_ovf = 1'b0;
`endif

    // Loading from IDLE cannot overflow because ACCW > SIZEIN.
    assign sum_o = load_i ? din_ext : add_sum;
    assign ovf_o = load_i ? 1'b0 : (ovf_q | add_ovf);

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (load_i || add_i) begin
            acc_d = sum_o;
            ovf_d = ovf_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (ce) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/cacc_frame.sv
// cacc_frame -- complex (re/im) frame accumulator with valid/ready handshakes.
// Sums every accepted beat of a frame and presents the total, beat count and
// overflow flag once the frame closes (s_last or FRAME_MAX beats).
// Build option: CACC_FRAME_SAT_EN selects saturating adds with overflow
// reporting; without it adds wrap and m_ovf is always 0.
//
// state | meaning
// IDLE  | no beat of the current frame accepted yet
// ACC   | at least one beat accepted, frame still open
// HOLD  | result presented on m_*, waiting for m_ready
//
// Ports:
//   clk, rst_n, ce          clock, async active-low reset, clock enable
//   s_valid/s_ready/s_last  input beat handshake and frame delimiter
//   ar, ai                  signed complex input sample (SIZEIN bits)
//   m_valid/m_ready         result handshake
//   sr, si                  signed complex frame sum (ACCW bits)
//   m_cnt                   beats in the frame, m_ovf saturation seen
module cacc_frame
    import cacc_frame_pkg::*;
#(
    parameter  int SIZEIN    = 16,
    parameter  int ACCW      = 24,
    parameter  int FRAME_MAX = 1024,
    localparam int CW        = $clog2(FRAME_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_last,
    input  logic signed [SIZEIN-1:0] ar,
    input  logic signed [SIZEIN-1:0] ai,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [ACCW-1:0]   sr,
    output logic signed [ACCW-1:0]   si,
    output logic [CW-1:0]            m_cnt,
    output logic                     m_ovf
);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic signed [ACCW-1:0] sr_q, si_q;
    logic [CW-1:0]          m_cnt_q;
    logic                   m_ovf_q;
    logic                   accept, consume, close;
    logic                   in_idle, in_acc;
    logic signed [ACCW-1:0] sum_r, sum_i;
    logic                   ovf_r, ovf_i;

    assign in_idle = (state_q == IDLE);
    assign in_acc  = (state_q == ACC);
    assign s_ready = (state_q != HOLD);
    assign m_valid = (state_q == HOLD);

    // s_ready is low in HOLD, so a beat can never share a cycle with consumption.
    assign accept  = s_valid & s_ready & ce;
    assign consume = m_valid & m_ready & ce;
    assign cnt_inc = in_idle ? CW'(1) : cnt_q + CW'(1);
    assign close   = accept & (s_last | (cnt_inc == CW'(FRAME_MAX)));

    cacc_lane #(.SIZEIN(SIZEIN), .ACCW(ACCW)) u_lane_re (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .load_i (accept & in_idle),
        .add_i  (accept & in_acc),
        .clr_i  (close),
        .din_i  (ar),
        .sum_o  (sum_r),
        .ovf_o  (ovf_r)
    );

    cacc_lane #(.SIZEIN(SIZEIN), .ACCW(ACCW)) u_lane_im (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .load_i (accept & in_idle),
        .add_i  (accept & in_acc),
        .clr_i  (close),
        .din_i  (ai),
        .sum_o  (sum_i),
        .ovf_o  (ovf_i)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (accept) state_d = close ? HOLD : ACC;
            ACC:  if (close)  state_d = HOLD;
            HOLD: if (consume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (close) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers load only on the closing beat and hold through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            si_q    <= '0;
            m_cnt_q <= '0;
            m_ovf_q <= 1'b0;
        end else if (close) begin
            sr_q    <= sum_r;
            si_q    <= sum_i;
            m_cnt_q <= cnt_inc;
            m_ovf_q <= ovf_r | ovf_i;
        end
    end

    assign sr    = sr_q;
    assign si    = si_q;
    assign m_cnt = m_cnt_q;
`ifdef CACC_FRAME_SAT_EN
    assign m_ovf = m_ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = m_ovf_q;
    assign m_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_cacc_frame.sv
// tb_cacc_frame -- randomized and directed bench for cacc_frame.
// Three instances: default parameters, FRAME_MAX=4, and ACCW=17. Only the
// selected instance sees s_valid; a frame-level reference model predicts
// outputs. CACC_FRAME_SAT_EN selects the saturating expectations.
module tb_cacc_frame;

`ifdef CACC_FRAME_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic m_ready = 1'b0;
    logic signed [15:0] ar = '0;
    logic signed [15:0] ai = '0;
    logic [2:0] sv;
    int sel = 0;

    logic s_ready_a, m_valid_a, m_ovf_a;
    logic signed [23:0] sr_a, si_a;
    logic [10:0] cnt_a;
    logic s_ready_b, m_valid_b, m_ovf_b;
    logic signed [23:0] sr_b, si_b;
    logic [2:0] cnt_b;
    logic s_ready_c, m_valid_c, m_ovf_c;
    logic signed [16:0] sr_c, si_c;
    logic [10:0] cnt_c;

    always #5 clk = ~clk;

    always_comb begin
        sv = 3'b000;
        case (sel)
            0: sv[0] = s_valid;
            1: sv[1] = s_valid;
            default: sv[2] = s_valid;
        endcase
    end

    cacc_frame dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .s_valid(sv[0]), .s_ready(s_ready_a),
        .s_last(s_last), .ar(ar), .ai(ai), .m_valid(m_valid_a), .m_ready(m_ready),
        .sr(sr_a), .si(si_a), .m_cnt(cnt_a), .m_ovf(m_ovf_a)
    );

    cacc_frame #(.FRAME_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce), .s_valid(sv[1]), .s_ready(s_ready_b),
        .s_last(s_last), .ar(ar), .ai(ai), .m_valid(m_valid_b), .m_ready(m_ready),
        .sr(sr_b), .si(si_b), .m_cnt(cnt_b), .m_ovf(m_ovf_b)
    );

    cacc_frame #(.ACCW(17)) dut_c (
        .clk(clk), .rst_n(rst_n), .ce(ce), .s_valid(sv[2]), .s_ready(s_ready_c),
        .s_last(s_last), .ar(ar), .ai(ai), .m_valid(m_valid_c), .m_ready(m_ready),
        .sr(sr_c), .si(si_c), .m_cnt(cnt_c), .m_ovf(m_ovf_c)
    );

    // Observed outputs of the selected instance, widened to 64 bits.
    logic signed [63:0] o_mv, o_rdy, o_sr, o_si, o_cnt, o_ovf;
    always_comb begin
        case (sel)
            0: begin
                o_mv = 64'(m_valid_a); o_rdy = 64'(s_ready_a); o_ovf = 64'(m_ovf_a);
                o_sr = 64'(sr_a); o_si = 64'(si_a); o_cnt = 64'(cnt_a);
            end
            1: begin
                o_mv = 64'(m_valid_b); o_rdy = 64'(s_ready_b); o_ovf = 64'(m_ovf_b);
                o_sr = 64'(sr_b); o_si = 64'(si_b); o_cnt = 64'(cnt_b);
            end
            default: begin
                o_mv = 64'(m_valid_c); o_rdy = 64'(s_ready_c); o_ovf = 64'(m_ovf_c);
                o_sr = 64'(sr_c); o_si = 64'(si_c); o_cnt = 64'(cnt_c);
            end
        endcase
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    // Reference model: frame sums in plain integer arithmetic.
    int     fm = 1024;
    int     w = 24;
    longint m_ar, m_ai, e_sr, e_si, e_cnt;
    int     m_cnt;
    bit     m_ovf_acc, m_pend, m_acc, e_ovf;
    int     n_out = 0;
    longint last_sr, last_si, last_cnt, last_ovf;

    function automatic longint madd(input longint a, input longint b, input int width,
                                    output bit o);
        longint hi, s, span;
        span = longint'(1) << width;
        hi   = (longint'(1) << (width - 1)) - 1;
        s    = a + b;
        o    = 1'b0;
        if (SAT_EN) begin
            if (s > hi) begin s = hi; o = 1'b1; end
            else if (s < -hi - 1) begin s = -hi - 1; o = 1'b1; end
        end else begin
            s = s & (span - 1);
            if (s > hi) s = s - span;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_ar = 0; m_ai = 0; m_cnt = 0; m_ovf_acc = 1'b0; m_pend = 1'b0;
        e_sr = 0; e_si = 0; e_cnt = 0; e_ovf = 1'b0;
    endtask

    task automatic model_tick();
        bit o1, o2;
        m_acc = 1'b0;
        if (!ce) return;
        if (m_pend) begin
            if (m_ready) m_pend = 1'b0;
        end else if (s_valid) begin
            m_acc = 1'b1;
            if (m_cnt == 0) begin
                m_ar = ar; m_ai = ai;
            end else begin
                m_ar = madd(m_ar, longint'(ar), w, o1);
                m_ai = madd(m_ai, longint'(ai), w, o2);
                m_ovf_acc = m_ovf_acc | o1 | o2;
            end
            m_cnt++;
            if (s_last || m_cnt == fm) begin
                e_sr = m_ar; e_si = m_ai; e_cnt = m_cnt; e_ovf = m_ovf_acc;
                m_pend = 1'b1;
                m_ar = 0; m_ai = 0; m_cnt = 0; m_ovf_acc = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("m_valid", o_mv, 64'(m_pend));
        chk("s_ready", o_rdy, 64'(!m_pend));
        chk("sr", o_sr, e_sr);
        chk("si", o_si, e_si);
        chk("m_cnt", o_cnt, e_cnt);
        chk("m_ovf", o_ovf, 64'(e_ovf));
    endtask

    // One clock: inputs were set at the previous negedge.
    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        compare_all();
        if (o_mv == 1) begin
            n_out++;
            last_sr = o_sr; last_si = o_si; last_cnt = o_cnt; last_ovf = o_ovf;
        end
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic beat(input int re, input int im, input bit last);
        bit done = 1'b0;
        s_valid = 1'b1; ar = 16'(re); ai = 16'(im); s_last = last;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = m_acc;
        end
        if (!done) chk("beat_timeout", 64'(0), 64'(1));
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic set_sel(input int k);
        sel = k;
        fm  = (k == 1) ? 4 : 1024;
        w   = (k == 2) ? 17 : 24;
        do_reset();
    endtask

    task automatic rand_run(input int cycles, input int last_div);
        for (int i = 0; i < cycles; i++) begin
            ce      = ($urandom_range(0, 7) != 0);
            s_valid = $urandom_range(0, 1) == 1;
            s_last  = ($urandom_range(0, last_div) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            ar      = 16'($urandom);
            ai      = 16'($urandom);
            step();
        end
        ce = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) step();
    endtask

    int n0;

    initial begin
        @(negedge clk);
        ce = 1'b1;
        set_sel(0);

        // Three-beat frame, result one cycle after the closing beat.
        m_ready = 1'b1;
        beat(3, -1, 0); beat(5, 2, 0); beat(-2, 4, 1);
        chk("s1_mv", o_mv, 1); chk("s1_sr", o_sr, 6); chk("s1_si", o_si, 5);
        chk("s1_cnt", o_cnt, 3); chk("s1_ovf", o_ovf, 0);
        step();

        // One-beat frame at the input extremes.
        beat(-32768, 32767, 1);
        chk("s2_sr", o_sr, -32768); chk("s2_si", o_si, 32767); chk("s2_cnt", o_cnt, 1);
        step();

        // Back-pressure: result held, no beats taken while m_ready is low.
        m_ready = 1'b0;
        beat(10, 20, 0); beat(30, -5, 1);
        s_valid = 1'b1; ar = 16'sd100; ai = 16'sd100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s4_mv", o_mv, 1); chk("s4_rdy", o_rdy, 0);
            chk("s4_sr", o_sr, 40); chk("s4_si", o_si, 15);
        end
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("s4_rel_mv", o_mv, 0); chk("s4_rel_rdy", o_rdy, 1);
        beat(2, 3, 1);
        chk("s4_next_cnt", o_cnt, 1); chk("s4_next_sr", o_sr, 2);
        step();

        // Reset in the middle of a frame discards it.
        beat(9, 9, 0); beat(9, 9, 0);
        do_reset();
        chk("s6_rst_sr", o_sr, 0); chk("s6_rst_mv", o_mv, 0); chk("s6_rst_rdy", o_rdy, 1);
        step(); step();
        chk("s6_nomv", o_mv, 0);
        beat(7, 7, 1);
        chk("s6_sr", o_sr, 7); chk("s6_si", o_si, 7); chk("s6_cnt", o_cnt, 1);
        step();

        rand_run(400, 3);

        // FRAME_MAX=4 closes on count; the last two beats open a new frame.
        set_sel(1);
        m_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 6; i++) beat(1, 1, 0);
        step();
        chk("s3_nout", 64'(n_out - n0), 1);
        chk("s3_sr", last_sr, 4); chk("s3_cnt", last_cnt, 4);
        chk("s3_open_mv", o_mv, 0);
        beat(1, 1, 1);
        chk("s3_f2_cnt", o_cnt, 3); chk("s3_f2_sr", o_sr, 3);
        step();
        rand_run(300, 7);

        // ACCW=17 overflow behaviour.
        set_sel(2);
        m_ready = 1'b1;
        beat(32767, -32768, 0); beat(32767, -32768, 0); beat(32767, -32768, 1);
        chk("s5_sr", o_sr, SAT_EN ? 65535 : -32771);
        chk("s5_si", o_si, SAT_EN ? -65536 : 32768);
        chk("s5_ovf", o_ovf, SAT_EN ? 1 : 0);
        chk("s5_cnt", o_cnt, 3);
        step();
        rand_run(300, 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule
